booth_pp_reduce: RTL
====================

Name: booth_pp_reduce

Overview:
- Downstream consumer of the radix-4 Booth partial-product generator in the 8x8 signed Booth multiplier.
- Sums the four aligned 16-bit partial products plus the sign-compensation word through a carry-save tree and a final carry-propagate adder.
- Three pipeline register stages with valid/ready flow control.
- Output is the 16-bit two's-complement product, modulo 2^16.

Parameters:
- WIDTH, 16, width of every partial product, sign_comp and product; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  pp0..pp3/sign_comp hold a valid set this cycle.
- in_ready  output  1  block accepts the input set this cycle.
- pp0  input  WIDTH  partial product 0, already aligned.
- pp1  input  WIDTH  partial product 1, already aligned.
- pp2  input  WIDTH  partial product 2, already aligned.
- pp3  input  WIDTH  partial product 3, already aligned.
- sign_comp  input  WIDTH  sign-compensation term.
- out_valid  output  1  product is valid.
- out_ready  input  1  downstream accepts product.
- product  output  WIDTH  sum of all five inputs, modulo 2^WIDTH.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid flags clear; out_valid=0; product=0; all internal sum/carry registers=0.
  - in_ready=1 immediately while rst is high and after it releases.
- CSA cell: s = a^b^c; cy = ((a&b)|(a&c)|(b&c)) << 1, truncated to WIDTH (bit WIDTH discarded).
- S1, registered on accept:
  - CSA(pp0,pp1,pp2) -> (sa,ca).
  - CSA(sa,ca,pp3) -> (s1,c1).
  - sign_comp is registered alongside as sc1.
- S2: CSA(s1,c1,sc1) -> (s2,c2), registered.
- S3: product = s2 + c2 truncated to WIDTH, registered into the output register.
- Latency: 3 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stalls. Throughput is 1 per cycle.
- Handshake:
  - Per stage k, advance_k = !valid_k | advance_{k+1}; for the output stage, advance_3 = !out_valid | out_ready.
  - in_ready = advance_1, combinational from the stage valids and out_ready. There is no combinational path from in_valid to in_ready.
  - A stage loads when its upstream is valid and advance_k=1.
  - Its valid flag becomes the upstream valid when advance_k=1, and holds otherwise.
  - Data registers hold while stalled. Bubbles collapse.
- While out_valid=1 and out_ready=0, product and out_valid stay stable.
- Simultaneous accept at input and output with a full pipe: every stage shifts, no loss, no duplication.
- Full pipe (3 valid, out_ready=0): in_ready=0; in_valid is ignored and inputs need not be held by this block.
- Empty pipe: out_valid=0, and product holds its last value.
- Reset mid-operation drops all in-flight results. No partial output appears after rst releases.
- Overflow: bits above WIDTH-1 are discarded at every CSA and at the final adder. No saturation.

Decomposition:
- Shared package booth_pkg:
  - localparam PP_WIDTH=16 and NUM_PP=4.
  - A typedef for a WIDTH-bit word.
  - A function csa3(a,b,c) returning {sum,carry}.
- One natural sub-module, booth_csa32: a combinational WIDTH-bit 3:2 compressor, instantiated three times.
- Pipeline control stays in booth_pp_reduce.

Test Plan:
- Single transfer, out_ready=1: pp0..pp3 = 0x0001, 0x0002, 0x0004, 0x0008, sign_comp=0x0010 -> product=0x001F, out_valid exactly 3 cycles after accept.
- Wrap-around: all five inputs 0xFFFF -> product 0xFFFB.
- Chained with the Booth encoder + pp generator, streaming back-to-back with out_ready=1:
  - 3*5 -> 0x000F.
  - -128*-128 -> 0x4000.
  - 127*-128 -> 0xC080.
  - -1*-1 -> 0x0001.
  - Expect one result per cycle, in order.
- Backpressure:
  - Stream 5 sets with out_ready=0 -> in_ready drops after 3 accepts, and the first product is stable.
  - Raise out_ready -> all 5 results emerge in order with no duplicates.
- Random valid/ready: 1000 random 8x8 signed pairs via the generator, with random in_valid/out_ready -> every product equals a*b mod 2^16, count in equals count out.
- Reset mid-stream: assert rst with 2 items in flight -> out_valid=0 and product=0 asynchronously, in_ready=1. After release, the first new input yields only its own result 3 cycles later.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth partial-product reduction path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package booth_pkg;

    localparam int PP_WIDTH = 16;
    localparam int NUM_PP   = 4;

    typedef logic [PP_WIDTH-1:0] word_t;

    // 3:2 compression of three words: returns {sum, carry}. The carry is the
    // majority vector shifted up one place; the bit pushed past the MSB is lost
    // because the whole datapath is modulo 2^PP_WIDTH.
    function automatic logic [2*PP_WIDTH-1:0] csa3(input word_t a, input word_t b, input word_t c);
        word_t maj;
        maj = (a & b) | (a & c) | (b & c);
        return {a ^ b ^ c, maj[PP_WIDTH-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/booth_csa32.sv
// Combinational WIDTH-bit 3:2 compressor (carry-save adder row).
// Latency: 0 cycles, purely combinational.
// Backpressure: none, no state.
// Ports: a, b, c - addends; s - bitwise sum; cy - carry vector already shifted
// left by one, truncated to WIDTH.
module booth_csa32
    import booth_pkg::*;
#(
    parameter int WIDTH = PP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] cy
);

    generate
        if (WIDTH == PP_WIDTH) begin : g_pkg
            assign {s, cy} = csa3(a, b, c);
        end else begin : g_generic
            logic [WIDTH-1:0] maj;
            assign maj = (a & b) | (a & c) | (b & c);
            assign s   = a ^ b ^ c;
            assign cy  = {maj[WIDTH-2:0], 1'b0};
        end
    endgenerate

endmodule

// File: rtl/booth_pp_reduce.sv
// Sums four aligned Booth partial products plus the sign-compensation word into a WIDTH-bit product.
// Latency: 3 cycles accept-to-out_valid, 1 result per cycle.
// Backpressure: valid/ready per stage with bubble collapse; in_ready is combinational from stage valids and out_ready only.
// Ports: clk, rst (async, active-high); in_valid/in_ready with pp0..pp3 and
// sign_comp; out_valid/out_ready with product.
module booth_pp_reduce
    import booth_pkg::*;
#(
    parameter int WIDTH = PP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pp0,
    input  logic [WIDTH-1:0] pp1,
    input  logic [WIDTH-1:0] pp2,
    input  logic [WIDTH-1:0] pp3,
    input  logic [WIDTH-1:0] sign_comp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
);

    // Stage 1 feeds two chained compressors; stage 2 one more.
    logic [WIDTH-1:0] sa, ca;
    logic [WIDTH-1:0] s1_nxt, c1_nxt;
    logic [WIDTH-1:0] s2_nxt, c2_nxt;

    logic [WIDTH-1:0] s1, c1, sc1;
    logic [WIDTH-1:0] s2, c2;
    logic             v1, v2;

    logic adv1, adv2, adv3;

    booth_csa32 #(.WIDTH(WIDTH)) u_csa_a (.a(pp0), .b(pp1), .c(pp2), .s(sa),     .cy(ca));
    booth_csa32 #(.WIDTH(WIDTH)) u_csa_b (.a(sa),  .b(ca),  .c(pp3), .s(s1_nxt), .cy(c1_nxt));
    booth_csa32 #(.WIDTH(WIDTH)) u_csa_c (.a(s1),  .b(c1),  .c(sc1), .s(s2_nxt), .cy(c2_nxt));

    // A stage may take new data when it is empty or its contents move on.
    assign adv3     = !out_valid || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            s1        <= '0;
            c1        <= '0;
            sc1       <= '0;
            s2        <= '0;
            c2        <= '0;
            product   <= '0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1  <= s1_nxt;
                    c1  <= c1_nxt;
                    sc1 <= sign_comp;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    s2 <= s2_nxt;
                    c2 <= c2_nxt;
                end
            end
            // product keeps its last value when the pipe drains empty.
            if (adv3) begin
                out_valid <= v2;
                if (v2) begin
                    product <= s2 + c2;
                end
            end
        end
    end

endmodule
